// File: rtl/int_root_seq_pkg.sv
// Shared constants for the sequential integer root engine: mode codes, FSM encodings
// and compile-time helpers.
package int_root_seq_pkg;

  localparam logic MODE_SQRT = 1'b0;
  localparam logic MODE_CBRT = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_TRIAL   = 2'd1;
  localparam state_t ST_COMPARE = 2'd2;
  localparam state_t ST_DONE    = 2'd3;

  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/int_root_seq_if.sv
// Operand/result handshake bundle for int_root_seq; slave is the engine side.
interface int_root_seq_if #(
  parameter int unsigned WIDTH = 32
);
  localparam int unsigned ROOT_W = (WIDTH + 1) / 2;

  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [WIDTH-1:0]  in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ROOT_W-1:0] root_out;
  logic [WIDTH-1:0]  rem_out;

  modport slave (
    input  in_valid, in_mode, in_data, out_ready,
    output in_ready, out_valid, root_out, rem_out
  );

  modport master (
    output in_valid, in_mode, in_data, out_ready,
    input  in_ready, out_valid, root_out, rem_out
  );

endinterface

// File: rtl/int_root_seq_trial_gen.sv
// Combinational trial subtrahend for one root digit: the increment from (2r)^k to (2r+1)^k.
module root_trial_gen
  import int_root_seq_pkg::*;
#(
  parameter int unsigned ROOT_W = 16,
  parameter int unsigned RW     = 36
) (
  input  logic [ROOT_W-1:0] root,
  input  logic              mode,
  output logic [RW-1:0]     trial
);

  logic [RW-1:0] c;

  always_comb begin
    c = RW'(root) << 1;
    if (mode == MODE_CBRT) begin
      trial = RW'(3) * c * (c + RW'(1)) + RW'(1);
    end else begin
      trial = (c << 1) | RW'(1);
    end
  end

endmodule

// File: rtl/int_root_seq.sv
// Radix-2 digit-recurrence square/cube root engine with exact remainder,
// one root bit per TRIAL/COMPARE pair.
module int_root_seq
  import int_root_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         abort,
  output logic         busy,
  int_root_seq_if.slave bus
);

  localparam int unsigned ROOT_W = (WIDTH + 1) / 2;
  localparam int unsigned RW     = WIDTH + 4;
  localparam int unsigned NB2    = ceil_div(WIDTH, 2);
  localparam int unsigned NB3    = ceil_div(WIDTH, 3);
  localparam int unsigned SW     = (2 * NB2 > 3 * NB3) ? 2 * NB2 : 3 * NB3;
  localparam int unsigned CW     = $clog2(NB2 + 1);

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [SW-1:0]     sh_q, sh_d;
  logic [RW-1:0]     rem_q, rem_d;
  logic [RW-1:0]     trial_q, trial_d;
  logic [ROOT_W-1:0] root_q, root_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [RW-1:0]     trial_next;
  logic [2:0]        grp;

  root_trial_gen #(
    .ROOT_W (ROOT_W),
    .RW     (RW)
  ) u_trial_gen (
    .root  (root_q),
    .mode  (mode_q),
    .trial (trial_next)
  );

  // Operand sits left-aligned in sh_q so the next digit group is always its top bits;
  // the left zero-padding to a whole number of groups falls out of the alignment shift.
  always_comb begin
    if (mode_q == MODE_CBRT) begin
      grp = sh_q[SW-1 -: 3];
    end else begin
      grp = {1'b0, sh_q[SW-1 -: 2]};
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    sh_d    = sh_q;
    rem_d   = rem_q;
    trial_d = trial_q;
    root_d  = root_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          mode_d  = bus.in_mode;
          rem_d   = '0;
          root_d  = '0;
          state_d = ST_TRIAL;
          if (bus.in_mode == MODE_CBRT) begin
            sh_d  = SW'(bus.in_data) << (SW - 3 * NB3);
            cnt_d = CW'(NB3);
          end else begin
            sh_d  = SW'(bus.in_data) << (SW - 2 * NB2);
            cnt_d = CW'(NB2);
          end
        end
      end
      ST_TRIAL: begin
        if (mode_q == MODE_CBRT) begin
          rem_d = (rem_q << 3) | RW'(grp);
          sh_d  = sh_q << 3;
        end else begin
          rem_d = (rem_q << 2) | RW'(grp);
          sh_d  = sh_q << 2;
        end
        trial_d = trial_next;
        state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (rem_q >= trial_q) begin
          rem_d  = rem_q - trial_q;
          root_d = {root_q[ROOT_W-2:0], 1'b1};
        end else begin
          root_d = {root_q[ROOT_W-2:0], 1'b0};
        end
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == CW'(1)) ? ST_DONE : ST_TRIAL;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      root_d  = '0;
      rem_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_SQRT;
      sh_q    <= '0;
      rem_q   <= '0;
      trial_q <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
      trial_q <= trial_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.root_out  = root_q;
  assign bus.rem_out   = rem_q[WIDTH-1:0];
  assign busy          = (state_q == ST_TRIAL) || (state_q == ST_COMPARE);

endmodule
